// File: rtl/neuron_sequencer_pkg.sv
// Shared types and constants for the neuron sequencer and its bias/activation datapath.
package neuron_sequencer_pkg;

    localparam int VARWIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        NEXT,
        DONE
    } state_t;

    localparam logic [VARWIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [VARWIDTH-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/adder32.sv
// Plain two's-complement adder shared by the accumulator-side datapaths.
module adder32
    import neuron_sequencer_pkg::*;
(
    input  logic [VARWIDTH-1:0] a,
    input  logic [VARWIDTH-1:0] b,
    output logic [VARWIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/bias_act_unit.sv
// Adds the per-neuron bias to the accumulator sum and derives the activation bit.
// Define SAT_ADD_EN to saturate on overflow instead of wrapping.
module bias_act_unit
    import neuron_sequencer_pkg::*;
(
    input  logic [VARWIDTH-1:0] sum,
    input  logic [VARWIDTH-1:0] bias,
    output logic [VARWIDTH-1:0] r,
    output logic                act_bit
);

    logic [VARWIDTH-1:0] raw;

    adder32 u_add (
        .a   (sum),
        .b   (bias),
        .sum (raw)
    );

`ifdef SAT_ADD_EN
    logic ovf;

    // Overflow only when both operands share a sign the result does not.
    assign ovf = (sum[VARWIDTH-1] == bias[VARWIDTH-1]) && (raw[VARWIDTH-1] != sum[VARWIDTH-1]);
    assign r   = !ovf ? raw : (sum[VARWIDTH-1] ? SAT_MIN : SAT_MAX);
`else
    assign r = raw;
`endif

    assign act_bit = ~r[VARWIDTH-1];

endmodule

// File: rtl/neuron_sequencer.sv
// Drives the tree accumulator neuron by neuron and stores biased sums plus activation bits.
// Optional SAT_ADD_EN build switch selects saturating bias addition in bias_act_unit.
module neuron_sequencer
    import neuron_sequencer_pkg::*;
#(
    parameter int NEURONS = 16,
    parameter int LAYERS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          num_neurons,
    output logic [7:0]          neuron_idx,
    input  logic [31:0]         bias,
    output logic                acc_en,
    output logic                acc_rst,
    input  logic                acc_rdy,
    input  logic [31:0]         acc_sum,
    input  logic [7:0]          rd_idx,
    output logic [31:0]         rd_data,
    output logic [NEURONS-1:0]  out_bits,
    output logic                busy,
    output logic                done,
    output logic                err,
    output state_t              fsm_state
);

    localparam int              IW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      NMAX  = 8'(NEURONS);
    localparam logic [CW-1:0]   TLAST = CW'(TIMEOUT - 1);

    // The accumulator needs LAYERS+3 RUN cycles; a shorter timeout could never succeed.
    if (TIMEOUT <= LAYERS + 3) begin : g_timeout_check
        $error("TIMEOUT must exceed the accumulator latency LAYERS+3");
    end

    state_t              state;
    state_t              state_next;
    logic [7:0]          idx;
    logic [7:0]          n;
    logic [7:0]          n_req;
    logic [CW-1:0]       cnt;
    logic [VARWIDTH-1:0] bank [NEURONS];
    logic [VARWIDTH-1:0] biased;
    logic                act_bit;
    logic                last_neuron;
    logic                timed_out;

    assign n_req       = (num_neurons > NMAX) ? NMAX : num_neurons;
    assign last_neuron = (idx == n - 8'd1);
    assign timed_out   = !acc_rdy && (cnt == TLAST);
    assign neuron_idx  = idx;
    assign fsm_state   = state;

    bias_act_unit u_bias_act (
        .sum     (acc_sum),
        .bias    (bias),
        .r       (biased),
        .act_bit (act_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Accumulator handshake: acc_en high only in RUN; acc_rdy is honoured only while
    // acc_en is high, and acc_sum must stay stable through the following CAPTURE cycle.
    always_comb begin
        state_next = state;
        acc_en     = 1'b0;
        acc_rst    = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (n_req == 8'd0) ? DONE : CLEAR;
            end
            CLEAR:   state_next = RUN;
            RUN: begin
                acc_en  = 1'b1;
                acc_rst = 1'b0;
                if (acc_rdy)        state_next = CAPTURE;
                else if (timed_out) state_next = NEXT;
            end
            CAPTURE: state_next = NEXT;
            NEXT:    state_next = last_neuron ? DONE : CLEAR;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            n        <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            out_bits <= '0;
            for (int i = 0; i < NEURONS; i++) bank[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n   <= n_req;
                        idx <= '0;
                        err <= 1'b0;
                    end
                end
                CLEAR: cnt <= '0;
                RUN: begin
                    if (timed_out) begin
                        err                   <= 1'b1;
                        bank[idx[IW-1:0]]     <= '0;
                        out_bits[idx[IW-1:0]] <= 1'b0;
                    end else if (!acc_rdy) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    bank[idx[IW-1:0]]     <= biased;
                    out_bits[idx[IW-1:0]] <= act_bit;
                end
                NEXT: begin
                    if (!last_neuron) idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < NMAX) rd_data = bank[rd_idx[IW-1:0]];
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Randomised scoreboard bench for neuron_sequencer with a simple accumulator stand-in.
module tb_neuron_sequencer;
    import neuron_sequencer_pkg::*;

    localparam int NEURONS = 16;
    localparam int LAYERS  = 4;
    localparam int TIMEOUT = 8;
    localparam int OK_CYC  = LAYERS + 6;
    localparam int TO_CYC  = TIMEOUT + 2;
    localparam int EW      = 1 + NEURONS + 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         num_neurons;
    logic [7:0]         neuron_idx;
    logic [31:0]        bias;
    logic               acc_en;
    logic               acc_rst;
    logic               acc_rdy;
    logic [31:0]        acc_sum;
    logic [7:0]         rd_idx;
    logic [31:0]        rd_data;
    logic [NEURONS-1:0] out_bits;
    logic               busy;
    logic               done;
    logic               err;
    state_t             fsm_state;

    logic [31:0]        sums   [NEURONS];
    logic [31:0]        biases [NEURONS];
    bit                 stall  [NEURONS];
    logic [31:0]        m_bank [NEURONS];
    logic [NEURONS-1:0] m_bits;
    logic [EW-1:0]      exp_q [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int en_cycles = 0;
    int acnt = 0;

    neuron_sequencer #(
        .NEURONS (NEURONS),
        .LAYERS  (LAYERS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_neurons (num_neurons),
        .neuron_idx  (neuron_idx),
        .bias        (bias),
        .acc_en      (acc_en),
        .acc_rst     (acc_rst),
        .acc_rdy     (acc_rdy),
        .acc_sum     (acc_sum),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .out_bits    (out_bits),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / accumulator stand-in ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (acc_en) en_cycles <= en_cycles + 1;

    // Accumulator answers in its (LAYERS+3)-th enabled cycle after a restart.
    always @(posedge clk or negedge rst) begin
        if (!rst)         acnt <= 0;
        else if (acc_rst) acnt <= 0;
        else if (acc_en)  acnt <= acnt + 1;
    end

    assign acc_rdy = acc_en && !stall[neuron_idx[3:0]] && (acnt == LAYERS + 2);
    assign acc_sum = (neuron_idx < NEURONS) ? sums[neuron_idx[3:0]] : 32'h0;
    assign bias    = (neuron_idx < NEURONS) ? biases[neuron_idx[3:0]] : 32'h0;

    // ---------------- reference model ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef SAT_ADD_EN
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [EW-1:0] model_run(input int num);
        int         n;
        int         lat;
        logic       e;
        logic [31:0] r;
        n   = (num > NEURONS) ? NEURONS : num;
        lat = 2;
        e   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (stall[i]) begin
                m_bank[i] = 32'h0;
                m_bits[i] = 1'b0;
                e         = 1'b1;
                lat      += TO_CYC;
            end else begin
                r         = ref_add(sums[i], biases[i]);
                m_bank[i] = r;
                m_bits[i] = ($signed(r) >= 0);
                lat      += OK_CYC;
            end
        end
        return {e, m_bits, 16'(lat)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            check("acc_en_vs_acc_rst", acc_en, !acc_rst);
            check("busy_vs_state", busy, fsm_state != IDLE);
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected no pending run");
                end else begin
                    e = exp_q.pop_front();
                    check("run_err", err, e[EW-1]);
                    check("run_out_bits", out_bits, e[EW-2 -: NEURONS]);
                    check("run_latency", cyc - t0 + 2, e[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input int num);
        @(negedge clk);
        num_neurons = 8'(num);
        start       = 1'b1;
        t0          = cyc + 1;
        @(negedge clk);
        start       = 1'b0;
        num_neurons = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < NEURONS * TO_CYC + 50; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL done_timeout: got no done pulse, expected one within budget");
            exp_q.delete();
        end
    endtask

    task automatic readback();
        for (int i = 0; i <= NEURONS; i++) begin
            rd_idx = 8'(i);
            #1;
            check($sformatf("rd_data[%0d]", i), rd_data, (i < NEURONS) ? m_bank[i] : 32'h0);
        end
        rd_idx = 8'd255;
        #1;
        check("rd_data[255]", rd_data, 32'h0);
        check("out_bits_hold", out_bits, m_bits);
    endtask

    task automatic run(input int num, input bit extra_start);
        exp_q.push_back(model_run(num));
        start_run(num);
        if (extra_start) begin
            repeat (25) @(negedge clk);
            start       = 1'b1;
            num_neurons = 8'd1;
            @(negedge clk);
            start       = 1'b0;
        end
        wait_done();
        @(negedge clk);
        readback();
    endtask

    task automatic randomize_neurons(input int stall_odds);
        for (int i = 0; i < NEURONS; i++) begin
            sums[i]   = $urandom;
            biases[i] = $urandom;
            stall[i]  = (stall_odds > 0) && ($urandom_range(0, stall_odds - 1) == 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  en_before;
        bit  ok;

        rst         = 1'b1;
        start       = 1'b0;
        num_neurons = 8'd0;
        rd_idx      = 8'd0;
        m_bits      = '0;
        for (int i = 0; i < NEURONS; i++) begin
            sums[i]   = 32'h0;
            biases[i] = 32'h0;
            stall[i]  = 1'b0;
            m_bank[i] = 32'h0;
        end

        #2 rst = 1'b0;
        #1;
        check("reset_neuron_idx", neuron_idx, 8'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_acc_en", acc_en, 1'b0);
        check("reset_acc_rst", acc_rst, 1'b1);
        check("reset_out_bits", out_bits, '0);
        check("reset_rd_data", rd_data, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Directed three-neuron run with a shared negative bias.
        sums[0] = 32'd10;
        sums[1] = -32'sd20;
        sums[2] = 32'd5;
        for (int i = 0; i < 3; i++) biases[i] = -32'sd3;
        run(3, 1'b0);
        rd_idx = 8'd1;
        #1;
        check("directed_bank1", rd_data, -32'sd23);
        check("directed_bits", out_bits[2:0], 3'b101);

        // Empty run: no accumulator activity, nothing stored.
        en_before = en_cycles;
        sums[0]   = 32'h1234_5678;
        run(0, 1'b0);
        check("empty_run_acc_en_cycles", en_cycles - en_before, 0);

        // Overflow at both ends of the signed range.
        sums[0]   = 32'h7FFF_FFF0;
        biases[0] = 32'd32;
        sums[1]   = 32'h8000_0000;
        biases[1] = 32'hFFFF_FFFF;
        run(2, 1'b0);
        rd_idx = 8'd0;
        #1;
`ifdef SAT_ADD_EN
        check("pos_overflow", rd_data, 32'h7FFF_FFFF);
        check("pos_overflow_bit", out_bits[0], 1'b1);
`else
        check("pos_overflow", rd_data, 32'h8000_0010);
        check("pos_overflow_bit", out_bits[0], 1'b0);
`endif

        // Timeout on neuron 0; the run still finishes neurons 1 and 2.
        randomize_neurons(0);
        stall[0] = 1'b1;
        run(3, 1'b0);
        stall[0] = 1'b0;

        // Clamped run with a stray start while busy.
        randomize_neurons(0);
        run(20, 1'b1);

        for (int r = 0; r < 8; r++) begin
            randomize_neurons(8);
            run($urandom_range(0, 20), 1'b0);
        end

        // Reset in the middle of neuron 1, after neuron 0 timed out.
        randomize_neurons(0);
        stall[0] = 1'b1;
        start_run(3);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (neuron_idx == 8'd1 && acc_en) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_neuron1_run", ok, 1'b1);
        check("err_before_reset", err, 1'b1);
        rst = 1'b0;
        #1;
        for (int i = 0; i < NEURONS; i++) m_bank[i] = 32'h0;
        m_bits = '0;
        check("midrun_neuron_idx", neuron_idx, 8'd0);
        check("midrun_busy", busy, 1'b0);
        check("midrun_done", done, 1'b0);
        check("midrun_err", err, 1'b0);
        check("midrun_acc_en", acc_en, 1'b0);
        check("midrun_acc_rst", acc_rst, 1'b1);
        readback();
        @(negedge clk);
        rst      = 1'b1;
        stall[0] = 1'b0;

        randomize_neurons(0);
        run(3, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
